usr_shift_ctrl: RTL and testbench

USR_SHIFT_CTRL -- requirements
Module: usr_shift_ctrl

---
 rtl/usr_shift_ctrl.sv | 155 +++++++++++++++
 tb/tb_usr_shift_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl: request-driven sequencer for a downstream universal shift
// register. Each request becomes one parallel-load cycle followed by up to DW
// enabled shift cycles and a one-cycle done pulse.
// Build option: define USR_CTRL_ROTATE_EN to feed the bit leaving the register
// back in as the serial bit (rotate) instead of the captured fill bit.
module usr_shift_ctrl #(
    parameter int DW = 8,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic          i_dir,
    input  logic [CW-1:0] i_shifts,
    input  logic          i_fill,
    input  logic          i_stall,
    output logic          o_ready,
    output logic          o_enb,
    output logic [1:0]    o_selector,
    output logic [DW-1:0] o_parallel,
    output logic          o_serialLeft,
    output logic          o_serialRight,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
    typedef enum logic [1:0] {SEL_HOLD, SEL_RIGHT, SEL_LEFT, SEL_LOAD} sel_e;

    localparam logic [CW-1:0] MAX_SHIFTS = CW'(DW);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic          dir_q, dir_d;
    logic          fill_q, fill_d;

    logic          ready_d, enb_d, busy_d, done_d, sl_d, sr_d;
    sel_e          sel_d;
    logic [DW-1:0] par_d;
    logic          serial_bit;

`ifdef USR_CTRL_ROTATE_EN
    logic unused_fill;
    assign unused_fill = fill_q;
`endif

    // Serial bit presented with the next issued shift.
    always_comb begin
`ifdef USR_CTRL_ROTATE_EN
        serial_bit = dir_q ? shadow_q[DW-1] : shadow_q[0];
`else
        serial_bit = fill_q;
`endif
    end

    // Next state plus the output values for the cycle being entered; outputs
    // are registered, so a stall sampled at an edge gates the following cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        dir_d    = dir_q;
        fill_d   = fill_q;
        ready_d  = 1'b0;
        enb_d    = 1'b0;
        sel_d    = SEL_HOLD;
        par_d    = '0;
        sl_d     = 1'b0;
        sr_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (o_ready && i_valid) begin
                    state_d  = LOAD;
                    dir_d    = i_dir;
                    fill_d   = i_fill;
                    cnt_d    = (i_shifts > MAX_SHIFTS) ? MAX_SHIFTS : i_shifts;
                    shadow_d = i_data;
                    ready_d  = 1'b0;
                    enb_d    = 1'b1;
                    sel_d    = SEL_LOAD;
                    par_d    = i_data;
                    busy_d   = 1'b1;
                end
            end
            LOAD, SHIFT: begin
                // The count holds shifts not yet issued, so zero means the
                // previous cycle (load or last shift) finished the operation.
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                    if (!i_stall) begin
                        enb_d = 1'b1;
                        cnt_d = cnt_q - CW'(1);
                        if (dir_q) begin
                            sel_d    = SEL_LEFT;
                            sl_d     = serial_bit;
                            shadow_d = {shadow_q[DW-2:0], serial_bit};
                        end else begin
                            sel_d    = SEL_RIGHT;
                            sr_d     = serial_bit;
                            shadow_d = {serial_bit, shadow_q[DW-1:1]};
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shadow_q      <= '0;
            dir_q         <= 1'b0;
            fill_q        <= 1'b0;
            o_ready       <= 1'b0;
            o_enb         <= 1'b0;
            o_selector    <= '0;
            o_parallel    <= '0;
            o_serialLeft  <= 1'b0;
            o_serialRight <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            dir_q         <= dir_d;
            fill_q        <= fill_d;
            o_ready       <= ready_d;
            o_enb         <= enb_d;
            o_selector    <= sel_d;
            o_parallel    <= par_d;
            o_serialLeft  <= sl_d;
            o_serialRight <= sr_d;
            o_busy        <= busy_d;
            o_done        <= done_d;
        end
    end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Scoreboard bench for usr_shift_ctrl: the driver queues the expected outcome
// of each accepted request; a monitor watches the DUT outputs every cycle and
// checks load, each shift, stalls, and the final register contents.
module tb_usr_shift_ctrl;

    localparam int DW = 8;
    localparam int CW = $clog2(DW + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_dir = 1'b0;
    logic [CW-1:0] i_shifts = '0;
    logic          i_fill = 1'b0;
    logic          i_stall = 1'b0;
    logic          o_ready, o_enb, o_serialLeft, o_serialRight, o_busy, o_done;
    logic [1:0]    o_selector;
    logic [DW-1:0] o_parallel;

    usr_shift_ctrl #(.DW(DW)) dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_data(i_data),
        .i_dir(i_dir), .i_shifts(i_shifts), .i_fill(i_fill), .i_stall(i_stall),
        .o_ready(o_ready), .o_enb(o_enb), .o_selector(o_selector),
        .o_parallel(o_parallel), .o_serialLeft(o_serialLeft),
        .o_serialRight(o_serialRight), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       dir;
        logic       fill;
        int         n;
        logic [7:0] fin;
        int         acc_cyc;
    } txn_t;

    txn_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   stall_en = 0;
    bit   junk_en = 0;
    logic stall_at_edge = 1'b0;
    logic rst_at_edge = 1'b1;

    // Inputs as the DUT saw them at the most recent rising edge.
    always @(posedge clock) begin
        cyc           <= cyc + 1;
        stall_at_edge <= i_stall;
        rst_at_edge   <= reset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Final register contents after n shifts, from the shift/rotate definition.
    function automatic logic [7:0] model_fin(input logic [7:0] d, input logic dir,
                                             input logic fill, input int n);
        logic [15:0] w;
        logic [7:0]  f;
`ifdef USR_CTRL_ROTATE_EN
        f = d;
        fill = 1'b0;
`else
        f = fill ? 8'hFF : 8'h00;
`endif
        if (dir) begin
            w = {d, f} << n;
            return w[15:8];
        end else begin
            w = {f, d} >> n;
            return w[7:0];
        end
    endfunction

    // ---------------- monitor ----------------
    txn_t       cur;
    bit         active = 0;
    bit         after_done = 0;
    bit         prev_rst = 1;
    int         shifts = 0;
    logic [7:0] m;
    logic [7:0] ds;
    logic       eb;

    always @(negedge clock) begin
        if (rst_at_edge) begin
            chk("reset_outputs", {o_ready, o_enb, o_selector, o_parallel, o_serialLeft,
                                  o_serialRight, o_busy, o_done}, 0);
            chk("reset_shadow", dut.shadow_q, 0);
            chk("reset_count", dut.cnt_q, 0);
            active     = 0;
            after_done = 0;
        end else begin
            if (prev_rst) chk("ready_after_reset", o_ready, 1);
            if (after_done) begin
                chk("ready_after_done", o_ready, 1);
                after_done = 0;
            end
            if (o_enb && o_selector == 2'd3) begin
                chk("load_while_active", active, 0);
                if (expq.size() == 0) begin
                    chk("load_without_request", 1, 0);
                end else begin
                    cur = expq.pop_front();
                    chk("load_latency", cyc, cur.acc_cyc + 1);
                    chk("load_parallel", o_parallel, cur.data);
                    chk("load_busy", o_busy, 1);
                    chk("load_ready", o_ready, 0);
                    active = 1;
                    shifts = 0;
                    m      = cur.data;
                    ds     = o_parallel;
                end
            end else if (active) begin
                if (o_done) begin
                    chk("shift_count", shifts, cur.n);
                    chk("downstream_value", ds, cur.fin);
                    chk("shadow_value", dut.shadow_q, cur.fin);
                    chk("done_quiet", {o_enb, o_selector, o_busy}, 0);
                    active     = 0;
                    after_done = 1;
                end else begin
                    chk("stall_gate", o_enb, !stall_at_edge);
                    chk("shift_busy", o_busy, 1);
                    if (o_enb) begin
                        chk("shift_overrun", shifts < cur.n, 1);
                        chk("shift_sel", o_selector, cur.dir ? 2 : 1);
`ifdef USR_CTRL_ROTATE_EN
                        eb = cur.dir ? m[7] : m[0];
`else
                        eb = cur.fill;
`endif
                        if (cur.dir) begin
                            chk("serial_left", o_serialLeft, eb);
                            chk("serial_right_idle", o_serialRight, 0);
                            ds = {ds[6:0], o_serialLeft};
                            m  = {m[6:0], eb};
                        end else begin
                            chk("serial_right", o_serialRight, eb);
                            chk("serial_left_idle", o_serialLeft, 0);
                            ds = {o_serialRight, ds[7:1]};
                            m  = {eb, m[7:1]};
                        end
                        shifts++;
                    end else begin
                        chk("stall_sel", o_selector, 0);
                    end
                end
            end else if (o_done || o_enb) begin
                chk("unexpected_activity", {o_done, o_enb}, 0);
            end
        end
        prev_rst = rst_at_edge;
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clock);
        if (stall_en) i_stall = ($urandom_range(0, 3) == 0);
    endtask

    task automatic send(input logic [7:0] d, input logic dir, input logic [CW-1:0] sh,
                        input logic fill);
        txn_t t;
        bit   ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            tick();
            if (o_ready) begin
                i_valid = 1'b1; i_data = d; i_dir = dir; i_shifts = sh; i_fill = fill;
                t.data = d; t.dir = dir; t.fill = fill;
                t.n = (int'(sh) > DW) ? DW : int'(sh);
                t.fin = model_fin(d, dir, fill, t.n);
                t.acc_cyc = cyc;
                expq.push_back(t);
                ok = 1;
            end else if (junk_en) begin
                i_valid  = 1'b1;
                i_data   = DW'($urandom);
                i_dir    = 1'($urandom);
                i_shifts = CW'($urandom);
                i_fill   = 1'($urandom);
            end else begin
                i_valid = 1'b0;
            end
        end
        if (!ok) chk("ready_timeout", 0, 1);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (k < 300 && (expq.size() != 0 || active || !o_ready)) begin
            tick();
            k++;
        end
        if (k >= 300) chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_shifts(input int s);
        int k = 0;
        while (k < 100 && !(active && shifts >= s)) begin
            tick();
            k++;
        end
        if (k >= 100) chk("shift_wait_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        send(8'h07, 1'b0, 4'd3, 1'b0);
        send(8'h09, 1'b1, 4'd2, 1'b1);
        send(8'h81, 1'b0, 4'd1, 1'b0);
        send(8'h5A, 1'b1, 4'd0, 1'b1);
        send(8'hC3, 1'b0, 4'd15, 1'b1);
        send(8'h3E, 1'b1, 4'd8, 1'b0);
        drain();

        // two-cycle stall in the middle of a shift run
        send(8'hA5, 1'b0, 4'd6, 1'b1);
        wait_shifts(2);
        i_stall = 1'b1;
        tick();
        tick();
        i_stall = 1'b0;
        drain();

        // reset aborts a shift run without a done pulse
        send(8'h3C, 1'b1, 4'd7, 1'b0);
        wait_shifts(1);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();

        stall_en = 1;
        junk_en  = 1;
        repeat (60) send(8'($urandom), 1'($urandom), CW'($urandom_range(0, 15)), 1'($urandom));
        stall_en = 0;
        i_stall  = 1'b0;
        drain();
        repeat (3) tick();
        chk("queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
